// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: fetches words one request at a time into a small
// queue and redirects the fetch stream on branches and jumps taken by the consumer.
`timescale 1ns/1ps
module inst_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Instrunction,
  output logic [31:0] Inst_pc,
  output logic        Inst_valid,
  input  logic        Inst_ready,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Extimm
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic        handshake;
  logic        redirect;
  logic        push;
  logic        pop;
  logic        issue;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;

  // The head is masked while empty so stale queue contents never leak out.
  always_comb begin
    Inst_valid    = (count != '0);
    Instrunction  = Inst_valid ? q_inst[rd_ptr] : 32'h0;
    Inst_pc       = Inst_valid ? q_pc[rd_ptr] : 32'h0;
    Imem_req      = (state != ST_IDLE);
    Imem_addr     = req_addr;

    handshake     = Inst_valid & Inst_ready;
    redirect      = handshake & ((Pcsrc == 2'b01) | (Pcsrc == 2'b10));
    pc_plus4      = Inst_pc + 32'd4;
    branch_target = pc_plus4 + (Extimm << 2);
    jump_target   = {pc_plus4[31:28], Instrunction[25:0], 2'b00};
    target        = (Pcsrc == 2'b01) ? branch_target : jump_target;

    push          = (state == ST_REQ) & Imem_ack & ~redirect;
    pop           = handshake & ~redirect;
    issue         = (state == ST_IDLE) & (count < DEPTH_C) & ~redirect;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state    <= ST_REQ;
            req_addr <= fetch_pc;
          end
        end
        // A redirect while the read is still in flight parks in FLUSH so the
        // returning word can be swallowed without disturbing the bus.
        ST_REQ: begin
          if (redirect)
            state <= Imem_ack ? ST_IDLE : ST_FLUSH;
          else if (Imem_ack)
            state <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (Imem_ack)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (redirect)
        fetch_pc <= target;
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;

      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr && push) begin
      q_inst[wr_ptr] <= Imem_rdata;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: randomized memory latency and consumer behaviour,
// checked against an architectural PC-stream model of the program being fetched.
`timescale 1ns/1ps
module tb_inst_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack = 1'b0;
  logic [31:0] Imem_rdata = 32'h0;
  logic [31:0] Instrunction;
  logic [31:0] Inst_pc;
  logic        Inst_valid;
  logic        Inst_ready = 1'b0;
  logic [1:0]  Pcsrc = 2'b00;
  logic [31:0] Extimm = 32'h0;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] req_log[$];
  int          lat = 0;
  bit          lat_rand = 0;
  int          ready_mode = 0;
  bit          rand_redirect = 0;
  bit          one_pop = 0;
  bit          mem_spur = 0;

  bit          plan_active = 0;
  bit          plan_anypc = 0;
  int          plan_cond = 0;
  logic [31:0] plan_pc = 32'h0;
  logic [31:0] plan_imm = 32'h0;
  logic [1:0]  plan_src = 2'b00;

  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] last_target = 32'h0;
  logic [31:0] stale_addr = 32'h0;
  int          redir_logn = 0;
  int          consumed = 0;

  bit          pend = 0;
  logic [31:0] pend_addr = 32'h0;
  int          waited = 0;
  int          cur_lat = 0;

  inst_prefetch #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .Clk          (Clk),
    .Clr          (Clr),
    .Imem_req     (Imem_req),
    .Imem_addr    (Imem_addr),
    .Imem_ack     (Imem_ack),
    .Imem_rdata   (Imem_rdata),
    .Instrunction (Instrunction),
    .Inst_pc      (Inst_pc),
    .Inst_valid   (Inst_valid),
    .Inst_ready   (Inst_ready),
    .Pcsrc        (Pcsrc),
    .Extimm       (Extimm)
  );

  always #5 Clk = ~Clk;

  // Program image: address 0x4 holds a jump whose index field is 0x100.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h4)
      return {6'h02, 26'h000_0100};
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] log_at(input int idx);
    if (idx >= 0 && idx < req_log.size())
      return req_log[idx];
    return 32'hBAD0_BAD1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Configures memory and consumer behaviour, then pulses Clr and checks the
  // post-reset outputs and the timing of the first request.
  task automatic applyStimulus(input int l, input bit lr, input int rm, input bit rr);
    lat = l;
    lat_rand = lr;
    ready_mode = rm;
    rand_redirect = rr;
    plan_active = 0;
    one_pop = 0;
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    req_log.delete();
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    checkOutput("rst_req", {31'b0, Imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, Inst_valid}, 32'h0);
    checkOutput("rst_inst", Instrunction, 32'h0);
    checkOutput("rst_pc", Inst_pc, 32'h0);
    mem_spur = 1;
    @(posedge Clk);
    #1;
    checkOutput("first_req", {31'b0, Imem_req}, 32'h1);
    checkOutput("first_addr", Imem_addr, RESET_PC);
  endtask

  task automatic setPlan(input logic [31:0] pc, input logic [1:0] src, input logic [31:0] imm,
                         input int cond, input bit anypc);
    plan_pc = pc;
    plan_src = src;
    plan_imm = imm;
    plan_cond = cond;
    plan_anypc = anypc;
    plan_active = 1;
  endtask

  task automatic waitPlan();
    for (int i = 0; i < 400 && plan_active; i++)
      runCycles(1);
    checkOutput("plan_fired", {31'b0, plan_active}, 32'h0);
  endtask

  task automatic waitConsumed(input int n);
    int c0;
    c0 = consumed;
    for (int i = 0; i < 400 && consumed < c0 + n; i++)
      runCycles(1);
    checkOutput("consume_progress", {31'b0, consumed >= c0 + n}, 32'h1);
  endtask

  task automatic waitReq(input int idx);
    for (int i = 0; i < 400 && req_log.size() <= idx; i++)
      runCycles(1);
    checkOutput("req_issued", {31'b0, req_log.size() > idx}, 32'h1);
  endtask

  // Memory: one request at a time, acks after a configurable wait, and checks
  // that a pending request's address holds steady.
  initial begin
    forever begin
      @(negedge Clk);
      if (Clr !== 1'b0) begin
        Imem_ack = 1'b0;
        pend = 0;
        waited = 0;
      end else if (mem_spur) begin
        Imem_ack = 1'b1;
        Imem_rdata = 32'hDEAD_BEEF;
        mem_spur = 0;
      end else if (Imem_req === 1'b1) begin
        if (!pend) begin
          pend = 1;
          pend_addr = Imem_addr;
          waited = 0;
          cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
          req_log.push_back(Imem_addr);
          checkOutput("addr_align", {30'b0, Imem_addr[1:0]}, 32'h0);
        end else begin
          checkOutput("addr_stable", Imem_addr, pend_addr);
        end
        if (waited >= cur_lat) begin
          Imem_ack = 1'b1;
          Imem_rdata = memword(pend_addr);
          pend = 0;
        end else begin
          Imem_ack = 1'b0;
          waited++;
        end
      end else begin
        Imem_ack = 1'b0;
      end
    end
  end

  // Consumer plus reference model: exp_pc is the architectural PC the program
  // should execute next, advanced by the sequential/branch/jump rules.
  initial begin
    logic        rdy;
    logic        hit;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] word;
    logic [31:0] pc4;
    logic [31:0] rnd;
    int          r;
    forever begin
      @(negedge Clk);
      #1;
      if (Clr !== 1'b0) begin
        exp_pc = RESET_PC;
        Inst_ready = 1'b0;
        Pcsrc = 2'b00;
        continue;
      end
      rdy = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 3) != 0) ||
            (one_pop && Inst_valid === 1'b1);
      r = int'($urandom_range(0, 15));
      rnd = $urandom;
      src = 2'b00;
      imm = 32'h0;
      if (rand_redirect) begin
        src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r < 5) ? 2'b11 : 2'b00;
        imm = {{22{rnd[9]}}, rnd[9:0]};
      end
      hit = plan_active && (Inst_valid === 1'b1) && (plan_anypc || exp_pc == plan_pc);
      if (hit) begin
        rdy = (plan_cond == 0) || (plan_cond == 1 && Imem_ack === 1'b1) ||
              (plan_cond == 2 && Imem_req === 1'b1 && Imem_ack === 1'b0);
        if (rdy) begin
          src = plan_src;
          imm = plan_imm;
        end
      end
      Inst_ready = rdy;
      Pcsrc = src;
      Extimm = imm;
      if (Inst_valid === 1'b1 && rdy) begin
        word = memword(exp_pc);
        checkOutput("head_pc", Inst_pc, exp_pc);
        checkOutput("head_inst", Instrunction, word);
        consumed++;
        one_pop = 0;
        if (hit) begin
          plan_active = 0;
          redir_logn = req_log.size();
          stale_addr = Imem_addr;
        end
        pc4 = exp_pc + 32'd4;
        case (src)
          2'b01:   exp_pc = pc4 + (imm << 2);
          2'b10:   exp_pc = {pc4[31:28], word[25:0], 2'b00};
          default: exp_pc = pc4;
        endcase
        last_target = exp_pc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    // Reset stream with zero-wait memory and an always-ready consumer.
    applyStimulus(0, 0, 1, 0);
    waitConsumed(4);
    checkOutput("stream_req0", log_at(0), 32'h0);
    checkOutput("stream_req3", log_at(3), 32'hC);

    // Backpressure: exactly four fetches, then one pop buys one more.
    applyStimulus(0, 0, 0, 0);
    runCycles(40);
    checkOutput("bp_fetches", req_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("bp_addr", log_at(i), 32'(4 * i));
    checkOutput("bp_req_idle", {31'b0, Imem_req}, 32'h0);
    checkOutput("bp_valid", {31'b0, Inst_valid}, 32'h1);
    checkOutput("bp_head_pc", Inst_pc, RESET_PC);
    one_pop = 1;
    runCycles(20);
    checkOutput("bp_popped", {31'b0, one_pop}, 32'h0);
    checkOutput("bp_fetches2", req_log.size(), 32'd5);
    checkOutput("bp_addr4", log_at(4), 32'h10);
    checkOutput("bp_req_idle2", {31'b0, Imem_req}, 32'h0);

    // Backward branch consumed at 0x8.
    applyStimulus(0, 0, 1, 0);
    setPlan(32'h8, 2'b01, 32'hFFFF_FFFE, 0, 0);
    waitPlan();
    waitReq(redir_logn);
    checkOutput("br_next_addr", log_at(redir_logn), 32'h4);
    waitConsumed(3);

    // Jump consumed while a slow read is outstanding.
    applyStimulus(3, 0, 1, 0);
    setPlan(32'h4, 2'b10, 32'h0, 2, 0);
    waitPlan();
    checkOutput("jmp_flush_req", {31'b0, Imem_req}, 32'h1);
    checkOutput("jmp_stale_addr", Imem_addr, stale_addr);
    checkOutput("jmp_flushed", {31'b0, Inst_valid}, 32'h0);
    waitReq(redir_logn);
    checkOutput("jmp_next_addr", log_at(redir_logn), 32'h400);
    waitConsumed(2);

    // Redirect in the same cycle as the memory ack.
    applyStimulus(0, 0, 0, 0);
    setPlan(32'h0, 2'b01, 32'h10, 1, 1);
    waitPlan();
    checkOutput("ack_redir_valid", {31'b0, Inst_valid}, 32'h0);
    checkOutput("ack_redir_req", {31'b0, Imem_req}, 32'h0);
    ready_mode = 1;
    waitReq(redir_logn);
    checkOutput("ack_redir_addr", log_at(redir_logn), last_target);
    waitConsumed(3);

    // Reset with three queued entries and a fourth read pending.
    applyStimulus(3, 0, 0, 0);
    for (int i = 0; i < 200 && req_log.size() < 4; i++)
      runCycles(1);
    checkOutput("mid_valid", {31'b0, Inst_valid}, 32'h1);
    checkOutput("mid_req", {31'b0, Imem_req}, 32'h1);
    checkOutput("mid_head_pc", Inst_pc, 32'h0);
    applyStimulus(3, 0, 1, 0);
    waitConsumed(2);

    // Fetch address wraps past the top of the address space.
    applyStimulus(0, 0, 1, 0);
    setPlan(32'h0, 2'b01, 32'h3FFF_FFFD, 0, 0);
    waitPlan();
    waitConsumed(4);
    checkOutput("wrap_a0", log_at(redir_logn), 32'hFFFF_FFF8);
    checkOutput("wrap_a1", log_at(redir_logn + 1), 32'hFFFF_FFFC);
    checkOutput("wrap_a2", log_at(redir_logn + 2), 32'h0);

    // Random latency, backpressure, redirects and occasional resets.
    for (int k = 0; k < 4; k++) begin
      int c0;
      applyStimulus(0, 1, 2, 1);
      c0 = consumed;
      runCycles(int'($urandom_range(400, 900)));
      checkOutput("rand_progress", {31'b0, consumed - c0 >= 40}, 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
